// File: rtl/audio_test_pkg.sv
// Shared types and constants for the audio test-sample source.
package audio_test_pkg;

  typedef enum logic [1:0] {
    MUTE    = 2'd0,
    SAW     = 2'd1,
    SQUARE  = 2'd2,
    CHAN_ID = 2'd3
  } audio_mode_t;

  // Channel-ID words place (ch+1) in the top nibble: shift = BIT_WIDTH - CHAN_ID_HEADROOM.
  localparam int CHAN_ID_HEADROOM = 4;

endpackage

// File: rtl/audio_rate_nco.sv
// Fractional NCO: toggles clk_out at exactly 2*RATE per CLK_FREQ_HZ enabled cycles, no drift.
module audio_rate_nco #(
  parameter int CLK_FREQ_HZ = 74250000,
  parameter int RATE        = 48000
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic enable,
  output logic clk_out,
  output logic rise_tick
);

  if (CLK_FREQ_HZ <= 4 * RATE) begin : g_bad_rate
    $error("audio_rate_nco: CLK_FREQ_HZ must exceed 4*RATE");
  end

  localparam int ACC_W = $clog2(CLK_FREQ_HZ) + 1;
  localparam logic [ACC_W:0] INC = (ACC_W+1)'(2 * RATE);
  localparam logic [ACC_W:0] LIM = (ACC_W+1)'(CLK_FREQ_HZ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic             wrap;

  // One extra bit on the sum so the compare never sees a truncated value.
  always_comb begin
    sum       = {1'b0, acc} + INC;
    wrap      = (sum >= LIM);
    rise_tick = enable & wrap & ~clk_out;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acc     <= '0;
      clk_out <= 1'b0;
    end else if (enable) begin
      acc <= wrap ? ACC_W'(sum - LIM) : ACC_W'(sum);
      if (wrap) clk_out <= ~clk_out;
    end
  end

endmodule

// File: rtl/audio_test_source.sv
// Audio test-sample source: NCO-timed sample strobe plus per-channel mute/saw/square/ID generator.
module audio_test_source
  import audio_test_pkg::*;
#(
  parameter int                   CLK_FREQ_HZ        = 74250000,
  parameter int                   AUDIO_RATE         = 48000,
  parameter int                   BIT_WIDTH          = 16,
  parameter int                   CHANNELS           = 2,
  parameter int                   SQUARE_HALF_PERIOD = 24,
  parameter logic [BIT_WIDTH-1:0] SQUARE_AMP         = 'h4000
) (
  input  logic                                clk_pixel,
  input  logic                                reset,
  input  logic                                enable,
  input  audio_mode_t                         mode,
  input  logic [BIT_WIDTH-1:0]                step,
  output logic                                clk_audio,
  output logic                                sample_valid,
  output logic [CHANNELS-1:0][BIT_WIDTH-1:0]  audio_sample_word,
  output logic [15:0]                         sample_count
);

  if (BIT_WIDTH < 16 || BIT_WIDTH > 24) begin : g_bad_width
    $error("audio_test_source: BIT_WIDTH must be 16..24");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_chan
    $error("audio_test_source: CHANNELS must be 1..8");
  end
  if (SQUARE_HALF_PERIOD < 1) begin : g_bad_sq
    $error("audio_test_source: SQUARE_HALF_PERIOD must be >= 1");
  end

  localparam int                   SQ_W   = (SQUARE_HALF_PERIOD > 1) ? $clog2(SQUARE_HALF_PERIOD) : 1;
  localparam logic [SQ_W-1:0]      SQ_LST = SQ_W'(SQUARE_HALF_PERIOD - 1);
  localparam logic [BIT_WIDTH-1:0] SQ_NEG = ~SQUARE_AMP + BIT_WIDTH'(1);

  logic            tick;
  logic [SQ_W-1:0] sq_cnt;
  logic            sq_neg;

  audio_rate_nco #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .RATE        (AUDIO_RATE)
  ) u_nco (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .enable    (enable),
    .clk_out   (clk_audio),
    .rise_tick (tick)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      sample_valid <= 1'b0;
      sample_count <= '0;
    end else begin
      sample_valid <= tick;
      if (tick) sample_count <= sample_count + 16'd1;
    end
  end

  // Square phase only advances on ticks taken in SQUARE mode, so leaving the mode freezes it.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      sq_cnt <= '0;
      sq_neg <= 1'b0;
    end else if (tick && mode == SQUARE) begin
      if (sq_cnt == SQ_LST) begin
        sq_cnt <= '0;
        sq_neg <= ~sq_neg;
      end else begin
        sq_cnt <= sq_cnt + SQ_W'(1);
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [BIT_WIDTH-1:0] ID_WORD =
      BIT_WIDTH'(i + 1) << (BIT_WIDTH - CHAN_ID_HEADROOM);

    always_ff @(posedge clk_pixel) begin
      if (reset) begin
        audio_sample_word[i] <= '0;
      end else if (tick) begin
        unique case (mode)
          MUTE:    audio_sample_word[i] <= '0;
          SAW:     audio_sample_word[i] <= (i % 2 == 0) ? audio_sample_word[i] + step
                                                        : audio_sample_word[i] - step;
          SQUARE:  audio_sample_word[i] <= sq_neg ? SQ_NEG : SQUARE_AMP;
          CHAN_ID: audio_sample_word[i] <= ID_WORD;
          default: audio_sample_word[i] <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_test_source.sv
// Randomized bench for audio_test_source against a tick-count/arithmetic reference model.
module tb_audio_test_source;
  import audio_test_pkg::*;

  localparam int CF = 1000;
  localparam int AR = 48;
  localparam int NCH = 4;

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  audio_mode_t mode = MUTE;
  logic [15:0] step = 16'h0;
  logic        clk_audio;
  logic        sample_valid;
  logic [NCH-1:0][15:0] words;
  logic [15:0] sample_count;

  audio_test_source #(
    .CLK_FREQ_HZ        (CF),
    .AUDIO_RATE         (AR),
    .BIT_WIDTH          (16),
    .CHANNELS           (NCH),
    .SQUARE_HALF_PERIOD (24),
    .SQUARE_AMP         (16'h4000)
  ) dut (
    .clk_pixel         (clk_pixel),
    .reset             (reset),
    .enable            (enable),
    .mode              (mode),
    .step              (step),
    .clk_audio         (clk_audio),
    .sample_valid      (sample_valid),
    .audio_sample_word (words),
    .sample_count      (sample_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: clk_audio level is the parity of total toggles, floor(n*2R/C) over n enabled cycles.
  longint      m_n;
  int          m_cnt;
  int          m_sq;
  bit          m_vld;
  logic [15:0] m_w [NCH];

  function automatic longint tog(input longint k);
    return (k * 2 * AR) / CF;
  endfunction

  function automatic bit tick_next();
    return (tog(m_n + 1) > tog(m_n)) && (tog(m_n + 1) % 2 == 1);
  endfunction

  task automatic step_cycle();
    logic        r_s, e_s;
    audio_mode_t md;
    logic [15:0] st;
    logic [63:0] ew;
    r_s = reset; e_s = enable; md = mode; st = step;
    @(posedge clk_pixel);
    m_vld = 1'b0;
    if (r_s) begin
      m_n = 0; m_cnt = 0; m_sq = 0;
      for (int i = 0; i < NCH; i++) m_w[i] = 16'h0;
    end else if (e_s) begin
      m_vld = tick_next();
      m_n++;
      if (m_vld) begin
        m_cnt = (m_cnt + 1) % 65536;
        for (int i = 0; i < NCH; i++) begin
          case (md)
            MUTE:    m_w[i] = 16'h0;
            SAW:     m_w[i] = (i % 2 == 0) ? m_w[i] + st : m_w[i] - st;
            SQUARE:  m_w[i] = ((m_sq / 24) % 2 == 0) ? 16'h4000 : 16'hC000;
            default: m_w[i] = 16'((i + 1) * 4096);
          endcase
        end
        if (md == SQUARE) m_sq++;
      end
    end
    #1;
    ew = {m_w[3], m_w[2], m_w[1], m_w[0]};
    chk("clk_audio", 64'(clk_audio), 64'(tog(m_n) % 2));
    chk("sample_valid", 64'(sample_valid), 64'(m_vld));
    chk("sample_count", 64'(sample_count), 64'(m_cnt));
    chk("words", words, ew);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0;
    step_cycle(); step_cycle();
    reset = 1'b0;
  endtask

  initial begin
    int  pulses, edges, hp_bad, consec, last_edge, dis_vld, lat, idx;
    bit  prev_clk, prev_vld, found;

    m_n = 0; m_cnt = 0; m_sq = 0;
    for (int i = 0; i < NCH; i++) m_w[i] = 16'h0;

    // Reset state
    do_reset();
    chk("rst_words", words, 64'h0);
    chk("rst_clk", 64'(clk_audio), 64'h0);

    // 1000 enabled cycles of SAW: rate, half-periods, strobe shape, wrap values
    enable = 1'b1; mode = SAW; step = 16'h1111;
    pulses = 0; edges = 0; hp_bad = 0; consec = 0; last_edge = 0;
    prev_clk = 1'b0; prev_vld = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      step_cycle();
      if (clk_audio != prev_clk) begin
        if (edges > 0 && (c - last_edge < 10 || c - last_edge > 11)) hp_bad++;
        edges++; last_edge = c;
      end
      if (sample_valid) begin
        pulses++;
        if (prev_vld) consec++;
        if (sample_count == 16'd1) begin
          chk("saw1_ch0", 64'(words[0]), 64'h1111);
          chk("saw1_ch1", 64'(words[1]), 64'hEEEF);
        end
        if (sample_count == 16'd16) begin
          chk("saw16_ch0", 64'(words[0]), 64'h1110);
          chk("saw16_ch1", 64'(words[1]), 64'hEEF0);
        end
      end
      prev_clk = clk_audio; prev_vld = sample_valid;
    end
    chk("pulses_1000", 64'(pulses), 64'd48);
    chk("edges_1000", 64'(edges), 64'd96);
    chk("half_period_bad", 64'(hp_bad), 64'd0);
    chk("vld_consec", 64'(consec), 64'd0);

    // Square: 24 high, 24 low, then high again
    do_reset();
    enable = 1'b1; mode = SQUARE;
    found = 1'b0;
    for (int c = 0; c < 1200 && !found; c++) begin
      step_cycle();
      if (sample_valid) begin
        idx = int'(sample_count);
        if (idx == 1 || idx == 24 || idx == 49) chk("sq_pos", words, 64'h4000_4000_4000_4000);
        if (idx == 25 || idx == 48)             chk("sq_neg", words, 64'hC000_C000_C000_C000);
        if (idx == 49) found = 1'b1;
      end
    end
    chk("sq_reached_49", 64'(found), 64'd1);

    // Channel ID, then MUTE requested mid-sample
    do_reset();
    enable = 1'b1; mode = CHAN_ID;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step_cycle();
      if (sample_valid && sample_count == 16'd2) found = 1'b1;
    end
    chk("chid_reached", 64'(found), 64'd1);
    chk("chid_words", words, 64'h4000_3000_2000_1000);
    for (int c = 0; c < 3; c++) step_cycle();
    mode = MUTE;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      step_cycle();
      if (sample_valid) begin
        chk("mute_tick", words, 64'h0);
        found = 1'b1;
      end else begin
        chk("mute_early", words, 64'h4000_3000_2000_1000);
      end
    end
    chk("mute_reached", 64'(found), 64'd1);

    // Freeze mid-stream for 200 cycles
    mode = SAW; step = 16'h0123;
    for (int c = 0; c < 37; c++) step_cycle();
    enable = 1'b0; dis_vld = 0;
    for (int c = 0; c < 200; c++) begin
      step_cycle();
      if (sample_valid) dis_vld++;
    end
    chk("disabled_vld", 64'(dis_vld), 64'd0);
    enable = 1'b1;
    for (int c = 0; c < 60; c++) step_cycle();

    // Randomized mode / step / enable traffic
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        mode = audio_mode_t'($urandom_range(0, 3));
        step = 16'($urandom);
      end
      step_cycle();
    end

    // Reset asserted on a tick cycle
    enable = 1'b1; mode = SAW; step = 16'h0777;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (tick_next()) found = 1'b1;
      else step_cycle();
    end
    chk("tick_found", 64'(found), 64'd1);
    reset = 1'b1;
    step_cycle();
    chk("rst_tick_vld", 64'(sample_valid), 64'd0);
    chk("rst_tick_words", words, 64'h0);
    chk("rst_tick_cnt", 64'(sample_count), 64'd0);
    reset = 1'b0;
    lat = 0; found = 1'b0;
    for (int c = 1; c <= 1548 && !found; c++) begin
      step_cycle();
      if (sample_valid) begin lat = c; found = 1'b1; end
    end
    chk("first_tick_latency", 64'(lat), 64'd11);
    chk("first_tick_ch0", 64'(words[0]), 64'h0777);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
